// File: rtl/frame_reader.sv
// frame_reader: 640x480@60 scan generator that fetches 8-bit pixels from a
// 320x240 framebuffer and drives a registered, sync-aligned DAC stream.
// Default build shows the image 1:1 centred with BORDER_COLOR around it.
// Define FRAME_READER_DOUBLE_EN to show every framebuffer pixel as 2x2 over
// the full visible frame instead.
// Pipeline: counters (stage 0) -> read address (stage 1) -> memory
// (RD_LATENCY) -> color_out register. Sync and valid flags travel through a
// matching delay line so everything leaves the block on the same cycle.
module frame_reader #(
  parameter int         RD_LATENCY   = 2,
  parameter logic [7:0] BORDER_COLOR = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  output logic [16:0] addr_out_rd,
  output logic        rd_enable,
  input  logic [7:0]  color_in,
  output logic [7:0]  color_out,
  output logic        hsync,
  output logic        vsync,
  output logic        video_active,
  output logic        frame_done
);

  localparam int DL = RD_LATENCY + 1;

  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd752;
  localparam logic [9:0] H_MAX    = 10'd799;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd492;
  localparam logic [9:0] V_MAX    = 10'd524;

  logic [9:0]    h_count_q, h_count_d;
  logic [9:0]    v_count_q, v_count_d;
  logic          frame_done_q, frame_done_d;

  logic          vis_0, src_0, hs_0, vs_0;
  logic [8:0]    row_0, col_0;
  logic [16:0]   row_ext, addr_0;

  logic [16:0]   rd_addr_q, rd_addr_d;
  logic          rd_en_q, rd_en_d;

  logic [DL-1:0] vid_pipe_q, vid_pipe_d;
  logic [DL-1:0] src_pipe_q, src_pipe_d;
  logic [DL-1:0] hs_pipe_q, hs_pipe_d;
  logic [DL-1:0] vs_pipe_q, vs_pipe_d;

  logic [7:0]    color_q, color_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;

  // Scan counters; frame_done is decoded from the next count so the pulse
  // lines up with the counters sitting at (0,480).
  always_comb begin
    h_count_d = h_count_q + 10'd1;
    v_count_d = v_count_q;
    if (h_count_q == H_MAX) begin
      h_count_d = '0;
      v_count_d = (v_count_q == V_MAX) ? '0 : v_count_q + 10'd1;
    end
    frame_done_d = (h_count_d == '0) && (v_count_d == V_VIS);
  end

  // Stage 0 decode: visibility, raw syncs, source window and read address.
  always_comb begin
    vis_0 = (h_count_q < H_VIS) && (v_count_q < V_VIS);
    hs_0  = !((h_count_q >= H_SYNC_S) && (h_count_q < H_SYNC_E));
    vs_0  = !((v_count_q >= V_SYNC_S) && (v_count_q < V_SYNC_E));
`ifdef FRAME_READER_DOUBLE_EN
    src_0 = vis_0;
    row_0 = v_count_q[9:1];
    col_0 = h_count_q[9:1];
`else
    // Window is 160..479 x 120..359; both bounds stay below 512, so the low
    // nine bits are enough for the offset subtraction inside the window.
    src_0 = (h_count_q >= 10'd160) && (h_count_q < 10'd480) &&
            (v_count_q >= 10'd120) && (v_count_q < 10'd360);
    row_0 = v_count_q[8:0] - 9'd120;
    col_0 = h_count_q[8:0] - 9'd160;
`endif
    // row*320 as two shifted copies; row <= 239 keeps this below 76800.
    row_ext = {8'd0, row_0};
    addr_0  = (row_ext << 8) + (row_ext << 6) + {8'd0, col_0};
  end

  // Stage 1 read request plus the flag delay line feeding the output stage.
  always_comb begin
    rd_en_d   = src_0;
    rd_addr_d = src_0 ? addr_0 : rd_addr_q;

    vid_pipe_d[0] = vis_0;
    src_pipe_d[0] = src_0;
    hs_pipe_d[0]  = hs_0;
    vs_pipe_d[0]  = vs_0;
    for (int i = 1; i < DL; i++) begin
      vid_pipe_d[i] = vid_pipe_q[i-1];
      src_pipe_d[i] = src_pipe_q[i-1];
      hs_pipe_d[i]  = hs_pipe_q[i-1];
      vs_pipe_d[i]  = vs_pipe_q[i-1];
    end
  end

  // Output stage: select blank, border or fetched pixel alongside its syncs.
  always_comb begin
    active_d = vid_pipe_q[DL-1];
    hsync_d  = hs_pipe_q[DL-1];
    vsync_d  = vs_pipe_q[DL-1];
    if (!vid_pipe_q[DL-1]) begin
      color_d = 8'h00;
    end else if (!src_pipe_q[DL-1]) begin
      color_d = BORDER_COLOR;
    end else begin
      color_d = color_in;
    end
  end

  // All state, synchronously reset; sync stages idle high.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_count_q    <= '0;
      v_count_q    <= '0;
      frame_done_q <= 1'b0;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      vid_pipe_q   <= '0;
      src_pipe_q   <= '0;
      hs_pipe_q    <= '1;
      vs_pipe_q    <= '1;
      color_q      <= 8'h00;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      active_q     <= 1'b0;
    end else begin
      h_count_q    <= h_count_d;
      v_count_q    <= v_count_d;
      frame_done_q <= frame_done_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      vid_pipe_q   <= vid_pipe_d;
      src_pipe_q   <= src_pipe_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      color_q      <= color_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      active_q     <= active_d;
    end
  end

  assign addr_out_rd  = rd_addr_q;
  assign rd_enable    = rd_en_q;
  assign color_out    = color_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_active = active_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader. A behavioural model tracks the scan position per
// cycle and derives every expected output from the timing rules; distant
// scan positions are reached by depositing new counter values.
module tb_frame_reader;

  localparam logic [7:0] BORDER = 8'hE0;

  logic        clock;
  logic        reset;
  logic [16:0] addr_out_rd;
  logic        rd_enable;
  logic [7:0]  color_in;
  logic [7:0]  color_out;
  logic        hsync, vsync, video_active, frame_done;

  logic [16:0] mem_d1, mem_d2;
  logic [9:0]  jh, jv;

  int total = 0;
  int bad   = 0;
  int ph_h[5];
  int ph_v[5];
  int since_rst;
  int m_rd;
  int m_addr;
  int hs_low, vs_low, fd_seen;

  typedef struct {
    int h;
    int v;
    int rd;
    int addr;
    int va;
    int color;
  } vec_t;
  vec_t vecs[$];

  frame_reader #(.RD_LATENCY(2), .BORDER_COLOR(BORDER)) dut (
    .clock(clock), .reset(reset), .addr_out_rd(addr_out_rd),
    .rd_enable(rd_enable), .color_in(color_in), .color_out(color_out),
    .hsync(hsync), .vsync(vsync), .video_active(video_active),
    .frame_done(frame_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] fmem(input logic [16:0] a);
    fmem = a[7:0] ^ a[16:9];
  endfunction

  // Two-cycle framebuffer returning fmem(addr).
  always @(posedge clock) begin
    mem_d1 <= addr_out_rd;
    mem_d2 <= mem_d1;
  end
  assign color_in = fmem(mem_d2);

  function automatic int vis_f(input int h, input int v);
    return (h < 640 && v < 480) ? 1 : 0;
  endfunction

  function automatic int src_f(input int h, input int v);
`ifdef FRAME_READER_DOUBLE_EN
    return vis_f(h, v);
`else
    return (h >= 160 && h < 480 && v >= 120 && v < 360) ? 1 : 0;
`endif
  endfunction

  function automatic int addr_f(input int h, input int v);
`ifdef FRAME_READER_DOUBLE_EN
    return (v / 2) * 320 + (h / 2);
`else
    return (v - 120) * 320 + (h - 160);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (model pos h=%0d v=%0d)",
               name, act, exp, ph_h[0], ph_v[0]);
    end
  endtask

  task automatic check_cycle();
    int eh, ev, ea, ehs, evs, ec;
    logic [16:0] a17;
    chk("rd_enable", int'(rd_enable), m_rd);
    chk("addr_out_rd", int'(addr_out_rd), m_addr);
    chk("frame_done", int'(frame_done), (ph_h[0] == 0 && ph_v[0] == 480) ? 1 : 0);
    if (since_rst >= 4) begin
      eh  = ph_h[4];
      ev  = ph_v[4];
      ea  = vis_f(eh, ev);
      ehs = (eh >= 656 && eh <= 751) ? 0 : 1;
      evs = (ev >= 490 && ev <= 491) ? 0 : 1;
      a17 = 17'(addr_f(eh, ev));
      if (ea == 0)              ec = 0;
      else if (src_f(eh, ev) == 0) ec = int'(BORDER);
      else                      ec = int'(fmem(a17));
    end else begin
      ea = 0; ehs = 1; evs = 1; ec = 0;
    end
    chk("video_active", int'(video_active), ea);
    chk("hsync", int'(hsync), ehs);
    chk("vsync", int'(vsync), evs);
    chk("color_out", int'(color_out), ec);
    if (!hsync) hs_low++;
    if (!vsync) vs_low++;
    if (frame_done) fd_seen++;
  endtask

  task automatic tick();
    int nh, nv;
    @(posedge clock);
    if (reset) begin
      since_rst = 0;
      m_rd = 0;
      m_addr = 0;
      nh = 0;
      nv = 0;
    end else begin
      m_rd = src_f(ph_h[0], ph_v[0]);
      if (m_rd != 0) m_addr = addr_f(ph_h[0], ph_v[0]);
      if (since_rst < 100) since_rst++;
      nh = ph_h[0] + 1;
      nv = ph_v[0];
      if (nh == 800) begin
        nh = 0;
        nv = (nv + 1) % 525;
      end
    end
    for (int i = 4; i > 0; i--) begin
      ph_h[i] = ph_h[i-1];
      ph_v[i] = ph_v[i-1];
    end
    ph_h[0] = nh;
    ph_v[0] = nv;
    @(negedge clock);
    check_cycle();
  endtask

  // Deposit a new scan position; called just after a negedge check.
  task jump(input int h, input int v);
    jh = 10'(h);
    jv = 10'(v);
    force dut.h_count_q = jh;
    force dut.v_count_q = jv;
    release dut.h_count_q;
    release dut.v_count_q;
    ph_h[0] = h;
    ph_v[0] = v;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ph_h[i] = 0;
      ph_v[i] = 0;
    end
    since_rst = 0;
    m_rd = 0;
    m_addr = 0;
    hs_low = 0;
    vs_low = 0;
    fd_seen = 0;

`ifdef FRAME_READER_DOUBLE_EN
    vecs.push_back('{3, 5, 1, 641, 1, 8'h80});
    vecs.push_back('{3, 3, 1, 321, 1, 8'h41});
    vecs.push_back('{639, 479, 1, 76799, 1, 8'h6A});
    vecs.push_back('{640, 479, 0, 0, 0, 8'h00});
    vecs.push_back('{0, 0, 1, 0, 1, 8'h00});
    vecs.push_back('{100, 500, 0, 0, 0, 8'h00});
`else
    vecs.push_back('{159, 200, 0, 0, 1, 8'hE0});
    vecs.push_back('{160, 120, 1, 0, 1, 8'h00});
    vecs.push_back('{479, 359, 1, 76799, 1, 8'h6A});
    vecs.push_back('{300, 200, 1, 25740, 1, 8'hBE});
    vecs.push_back('{3, 5, 0, 0, 1, 8'hE0});
    vecs.push_back('{700, 100, 0, 0, 0, 8'h00});
    vecs.push_back('{100, 500, 0, 0, 0, 8'h00});
`endif

    // Reset held for five cycles.
    repeat (5) begin
      tick();
      chk("rst_rd_enable", int'(rd_enable), 0);
      chk("rst_addr", int'(addr_out_rd), 0);
      chk("rst_color", int'(color_out), 0);
      chk("rst_hsync", int'(hsync), 1);
      chk("rst_vsync", int'(vsync), 1);
      chk("rst_active", int'(video_active), 0);
      chk("rst_frame_done", int'(frame_done), 0);
    end
    reset = 1'b0;
    tick();
    tick();
`ifdef FRAME_READER_DOUBLE_EN
    chk("first_rd", int'(rd_enable), 1);
    chk("first_addr", int'(addr_out_rd), 0);
`endif

    // Two natural lines: hsync low 96 cycles per line.
    hs_low = 0;
    repeat (1600) tick();
    chk("hsync_low_2lines", hs_low, 192);

    // Hand-computed pixel vectors.
    foreach (vecs[i]) begin
      jump(vecs[i].h, vecs[i].v);
      tick();
      chk("vec_rd", int'(rd_enable), vecs[i].rd);
      if (vecs[i].rd != 0) chk("vec_addr", int'(addr_out_rd), vecs[i].addr);
      repeat (3) tick();
      chk("vec_active", int'(video_active), vecs[i].va);
      chk("vec_color", int'(color_out), vecs[i].color);
    end

    // frame_done once around (0,480).
    jump(790, 479);
    fd_seen = 0;
    repeat (40) tick();
    chk("frame_done_count", fd_seen, 1);

    // Five lines around vertical sync.
    jump(0, 488);
    repeat (10) tick();
    hs_low = 0;
    vs_low = 0;
    fd_seen = 0;
    repeat (4000) tick();
    chk("vsync_low_cycles", vs_low, 1600);
    chk("hsync_low_5lines", hs_low, 480);
    chk("no_frame_done", fd_seen, 0);

    // Frame wrap 524 -> 0.
    jump(790, 524);
    repeat (30) tick();

    // One-cycle reset mid-frame at (300,200).
    jump(300, 200);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_active0", int'(video_active), 0);
    chk("midrst_color0", int'(color_out), 0);
    repeat (3) begin
      tick();
      chk("midrst_active", int'(video_active), 0);
      chk("midrst_color", int'(color_out), 0);
    end
    repeat (20) tick();

    // Cross the source window edges naturally.
    jump(700, 119);
    repeat (1800) tick();
    jump(700, 358);
    repeat (1800) tick();
    jump(700, 478);
    repeat (1800) tick();

    // Random positions, run lengths and resets.
    for (int it = 0; it < 40; it++) begin
      jump(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
      repeat (int'($urandom_range(4, 400))) tick();
      if ($urandom_range(0, 3) == 0) begin
        reset = 1'b1;
        repeat (int'($urandom_range(1, 3))) tick();
        reset = 1'b0;
        repeat (int'($urandom_range(4, 100))) tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
